seq_detect_prog: RTL and testbench

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

---
 rtl/seq_detect_prog.sv | 137 +++++++++++++
 tb/tb_seq_detect_prog.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector: matches the last cfg_len received bits
// against a loaded pattern, with overlapping or non-overlapping detection.
module seq_detect_prog #(
    parameter int unsigned MAX_LEN = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inp_bit,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               overlap_en,
    input  logic               cnt_clr,
    output logic               seq_seen,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err,
    output logic               armed
);

    localparam logic [LEN_W-1:0] LEN_MIN   = LEN_W'(2);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] COUNT_MAX = '1;

    typedef enum logic {
        UNCFG = 1'b0,
        HUNT  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [MAX_LEN-1:0] history;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   len;

    logic [MAX_LEN-1:0] hist_nxt;
    logic [MAX_LEN-1:0] pat_nxt;
    logic [LEN_W-1:0]   fill_nxt;
    logic [LEN_W-1:0]   len_nxt;
    logic               seen_nxt;
    logic               err_nxt;
    logic [CNT_W-1:0]   count_nxt;

    logic               cfg_legal_c;
    logic               shift_en_c;
    logic               match_c;
    logic [MAX_LEN-1:0] hist_shift_c;
    logic [MAX_LEN-1:0] len_mask_c;
    logic [LEN_W-1:0]   fill_inc_c;

    // Match evaluation on the post-shift history and fill
    always_comb begin
        cfg_legal_c  = (cfg_len >= LEN_MIN) && (cfg_len <= LEN_MAX);
        shift_en_c   = (state == HUNT) && in_valid && !cfg_load;
        hist_shift_c = {history[MAX_LEN-2:0], inp_bit};
        fill_inc_c   = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
        len_mask_c   = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            len_mask_c[i] = (LEN_W'(i) < len);
        end
        match_c = shift_en_c && (fill_inc_c >= len) &&
                  (((hist_shift_c ^ pattern) & len_mask_c) == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= UNCFG;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (cfg_load) begin
            state_nxt = cfg_legal_c ? HUNT : UNCFG;
        end
    end

    // Next values of history, configuration and registered outputs
    always_comb begin
        hist_nxt  = history;
        fill_nxt  = fill;
        pat_nxt   = pattern;
        len_nxt   = len;
        seen_nxt  = 1'b0;
        err_nxt   = cfg_err;
        count_nxt = match_count;
        if (cfg_load) begin
            hist_nxt = '0;
            fill_nxt = '0;
            err_nxt  = !cfg_legal_c;
            if (cfg_legal_c) begin
                pat_nxt   = cfg_pattern;
                len_nxt   = cfg_len;
                count_nxt = '0;
            end
        end else begin
            if (shift_en_c) begin
                hist_nxt = hist_shift_c;
                fill_nxt = (match_c && !overlap_en) ? '0 : fill_inc_c;
                seen_nxt = match_c;
            end
            if (cnt_clr) begin
                count_nxt = match_c ? CNT_W'(1) : '0;
            end else if (match_c && (match_count != COUNT_MAX)) begin
                count_nxt = match_count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history     <= '0;
            fill        <= '0;
            pattern     <= '0;
            len         <= '0;
            seq_seen    <= 1'b0;
            match_count <= '0;
            cfg_err     <= 1'b0;
            armed       <= 1'b0;
        end else begin
            history     <= hist_nxt;
            fill        <= fill_nxt;
            pattern     <= pat_nxt;
            len         <= len_nxt;
            seq_seen    <= seen_nxt;
            match_count <= count_nxt;
            cfg_err     <= err_nxt;
            armed       <= (state_nxt == HUNT);
        end
    end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: a vector table of per-cycle stimulus and
// expected outputs, plus a hand-written asynchronous-reset sequence.
module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       inp_bit;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       overlap_en;
    logic       cnt_clr;

    logic       seen8, err8, armed8;
    logic [7:0] cnt8;
    logic       seen2, err2, armed2;
    logic [1:0] cnt2;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) dut8 (
        .clk(clk), .reset(reset), .inp_bit(inp_bit), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .overlap_en(overlap_en), .cnt_clr(cnt_clr), .seq_seen(seen8),
        .match_count(cnt8), .cfg_err(err8), .armed(armed8)
    );

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .inp_bit(inp_bit), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .overlap_en(overlap_en), .cnt_clr(cnt_clr), .seq_seen(seen2),
        .match_count(cnt2), .cfg_err(err2), .armed(armed2)
    );

    typedef struct {
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       v;
        logic       b;
        logic       ovl;
        logic       clr;
        logic       e_seen;
        logic [7:0] e_cnt;
        logic       e_armed;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic [7:0] pat, input logic [3:0] len,
                       input logic v, input logic b, input logic ovl, input logic clr,
                       input logic es, input logic [7:0] ec, input logic ea, input logic ee);
        vec_t t;
        t.ld = ld; t.pat = pat; t.len = len; t.v = v; t.b = b; t.ovl = ovl; t.clr = clr;
        t.e_seen = es; t.e_cnt = ec; t.e_armed = ea; t.e_err = ee;
        vecs.push_back(t);
    endtask

    // Legal load, nothing else in that cycle
    task automatic vl(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        add(1'b1, pat, len, 1'b0, 1'b0, ovl, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    endtask

    // One valid bit while armed
    task automatic vb(input logic b, input logic ovl, input logic es, input logic [7:0] ec);
        add(1'b0, 8'h00, 4'd0, 1'b1, b, ovl, 1'b0, es, ec, 1'b1, 1'b0);
    endtask

    task automatic drive_idle();
        inp_bit = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; overlap_en = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic es, input logic [7:0] ec,
                             input logic ea, input logic ee);
        logic [7:0] ec2;
        ec2 = (ec > 8'd3) ? 8'd3 : ec;
        chk({tag, ".seen"},  32'(seen8),  32'(es));
        chk({tag, ".count"}, 32'(cnt8),   32'(ec));
        chk({tag, ".armed"}, 32'(armed8), 32'(ea));
        chk({tag, ".err"},   32'(err8),   32'(ee));
        chk({tag, ".seen2"}, 32'(seen2),  32'(es));
        chk({tag, ".cnt2"},  32'(cnt2),   32'(ec2));
    endtask

    initial begin
        // Overlapping 1011
        vl(8'h0B, 4'd4, 1'b1);
        vb(1, 1, 0, 0); vb(0, 1, 0, 0); vb(1, 1, 0, 0); vb(1, 1, 1, 1);
        vb(0, 1, 0, 1); vb(1, 1, 0, 1); vb(1, 1, 1, 2);
        add(0, 8'h00, 4'd0, 0, 1, 1, 0, 0, 8'd2, 1, 0);
        // Non-overlapping 1011
        vl(8'h0B, 4'd4, 1'b0);
        vb(1, 0, 0, 0); vb(0, 0, 0, 0); vb(1, 0, 0, 0); vb(1, 0, 1, 1);
        vb(0, 0, 0, 1); vb(1, 0, 0, 1); vb(1, 0, 0, 1);
        // 1111, overlapping then non-overlapping
        vl(8'h0F, 4'd4, 1'b1);
        vb(1, 1, 0, 0); vb(1, 1, 0, 0); vb(1, 1, 0, 0);
        vb(1, 1, 1, 1); vb(1, 1, 1, 2); vb(1, 1, 1, 3);
        vl(8'h0F, 4'd4, 1'b0);
        vb(1, 0, 0, 0); vb(1, 0, 0, 0); vb(1, 0, 0, 0);
        vb(1, 0, 1, 1); vb(1, 0, 0, 1); vb(1, 0, 0, 1);
        // Load with a coincident valid 1: that bit must not seed 1011
        add(1, 8'h0B, 4'd4, 1, 1, 1, 0, 0, 8'd0, 1, 0);
        vb(0, 1, 0, 0); vb(1, 1, 0, 0); vb(1, 1, 0, 0);
        add(1, 8'h0B, 4'd4, 1, 1, 1, 0, 0, 8'd0, 1, 0);
        vb(1, 1, 0, 0); vb(0, 1, 0, 0);
        add(0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 8'd0, 1, 0);
        vb(1, 1, 0, 0); vb(1, 1, 1, 1);
        add(0, 8'h00, 4'd0, 0, 0, 1, 0, 0, 8'd1, 1, 0);
        // Pattern 11, len 2: saturation on the 2-bit counter, clear vs match
        vl(8'h03, 4'd2, 1'b1);
        vb(1, 1, 0, 0);
        vb(1, 1, 1, 1); vb(1, 1, 1, 2); vb(1, 1, 1, 3); vb(1, 1, 1, 4); vb(1, 1, 1, 5);
        add(0, 8'h00, 4'd0, 1, 1, 1, 1, 1, 8'd1, 1, 0);
        add(0, 8'h00, 4'd0, 1, 0, 1, 1, 0, 8'd0, 1, 0);
        // Illegal lengths: unarmed, bits ignored
        add(1, 8'h0B, 4'd0, 0, 0, 1, 0, 0, 8'd0, 0, 1);
        add(0, 8'h00, 4'd0, 1, 1, 1, 0, 0, 8'd0, 0, 1);
        add(0, 8'h00, 4'd0, 1, 0, 1, 0, 0, 8'd0, 0, 1);
        add(0, 8'h00, 4'd0, 1, 1, 1, 0, 0, 8'd0, 0, 1);
        add(0, 8'h00, 4'd0, 1, 1, 1, 0, 0, 8'd0, 0, 1);
        add(1, 8'h0B, 4'd9, 0, 0, 1, 0, 0, 8'd0, 0, 1);
        add(1, 8'h01, 4'd1, 0, 0, 1, 0, 0, 8'd0, 0, 1);
        add(1, 8'hFF, 4'd8, 0, 0, 1, 0, 0, 8'd0, 1, 0);
        vl(8'h0B, 4'd4, 1'b1);
        vb(1, 1, 0, 0); vb(0, 1, 0, 0); vb(1, 1, 0, 0); vb(1, 1, 1, 1);

        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("reset", 1'b0, 8'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            cfg_load    = vecs[i].ld;
            cfg_pattern = vecs[i].pat;
            cfg_len     = vecs[i].len;
            in_valid    = vecs[i].v;
            inp_bit     = vecs[i].b;
            overlap_en  = vecs[i].ovl;
            cnt_clr     = vecs[i].clr;
            @(posedge clk);
            #1;
            check_all($sformatf("v%0d", i), vecs[i].e_seen, vecs[i].e_cnt,
                      vecs[i].e_armed, vecs[i].e_err);
        end

        // Async reset mid-pattern discards partial match and configuration
        drive_idle();
        cfg_load = 1'b1; cfg_pattern = 8'h0B; cfg_len = 4'd4; overlap_en = 1'b1;
        @(posedge clk); #1;
        cfg_load = 1'b0; in_valid = 1'b1;
        inp_bit = 1'b1; @(posedge clk); #1;
        inp_bit = 1'b0; @(posedge clk); #1;
        inp_bit = 1'b1; @(posedge clk); #1;
        check_all("pre_rst", 1'b0, 8'd0, 1'b1, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        #2;
        check_all("async_rst", 1'b0, 8'd0, 1'b0, 1'b0);
        reset = 1'b0;
        #2;
        in_valid = 1'b1; inp_bit = 1'b1;
        @(posedge clk); #1;
        check_all("post_rst", 1'b0, 8'd0, 1'b0, 1'b0);
        in_valid = 1'b0; cfg_load = 1'b1; cfg_len = 4'd0;
        @(posedge clk); #1;
        check_all("len0", 1'b0, 8'd0, 1'b0, 1'b1);
        drive_idle();
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
